button_debounce: RTL and testbench
==================================

// Module: button_debounce
// PURPOSE
//   Conditions one raw, asynchronous push-button input into clean, glitch-free events.
//   Sits upstream of the LED blink stage. Its press/long-press pulses drive rate/mode control.
//   Pipeline: synchronise -> debounce FSM -> registered one-cycle event pulses plus a stable level.
// PARAMETERS
//   DebounceCycles   50_000      consecutive stable cycles needed to accept a level change (>=1)
//   LongPressCycles  50_000_000  cycles held after accepted press before long_press_o fires (>=1)
//   SyncStages       2           flops in the input synchroniser (>=2)
//   ButtonActiveLow  0           1: btn_i low = pressed; inverted before the synchroniser
// PORTS
//   clk_i         input   1  system clock
//   rst_i         input   1  asynchronous reset, active-high
//   btn_i         input   1  raw button pin, asynchronous, bouncy
//   level_o       output  1  debounced pressed level (1 = pressed)
//   press_o       output  1  one-cycle pulse on accepted press
//   release_o     output  1  one-cycle pulse on accepted release
//   long_press_o  output  1  one-cycle pulse, at most once per press, after LongPressCycles held
// BEHAVIOUR
//   - One clock: clk_i. Reset is asynchronous and active-high on rst_i.
//   - rst_i clears all flops asynchronously:
//       synchroniser = not-pressed; FSM = RELEASED; counters = 0.
//       level_o, press_o, release_o, long_press_o all = 0.
//   - Elaboration $error if any parameter is below its minimum.
//   - Sample s = synchroniser output after polarity normalisation; 1 = pressed.
//   - Counter widths: $clog2(Max+1). Both counters saturate and never wrap.
//   - FSM (typedef in config_pkg): RELEASED, PRESS_PENDING, PRESSED, RELEASE_PENDING.
//     RELEASED:        s=1 -> PRESS_PENDING, deb_cnt=0.
//     PRESS_PENDING:   s=0 -> RELEASED (bounce rejected, deb_cnt=0).
//                      s=1 and deb_cnt==DebounceCycles-1 -> PRESSED; press_o=1 next cycle; hold_cnt=0.
//                      otherwise deb_cnt++.
//     PRESSED:         s=0 -> RELEASE_PENDING, deb_cnt=0.
//     RELEASE_PENDING: s=1 -> PRESSED (bounce rejected; hold_cnt NOT cleared).
//                      s=0 and deb_cnt==DebounceCycles-1 -> RELEASED; release_o=1 next cycle.
//                      otherwise deb_cnt++.
//   - Latency: btn_i stable from edge k gives press_o/release_o high at exactly cycle
//     k+SyncStages+DebounceCycles; level_o changes in that same cycle.
//   - level_o = 1 in PRESSED and RELEASE_PENDING.
//   - long_press_o:
//       hold_cnt increments every cycle in PRESSED/RELEASE_PENDING.
//       Fires once when hold_cnt reaches LongPressCycles-1; a sticky flag blocks refire.
//       Flag clears on entry to RELEASED.
//   - Simultaneous: press_o and long_press_o never share a cycle (LongPressCycles>=1).
//     Only one pulse output can be 1 in any cycle.
//   - Reset mid-press: level_o drops with rst_i, no release_o is generated.
//     If button still held after reset, a fresh press_o follows the full latency.
//   - All outputs are driven from flops; there is no combinational path from btn_i to any output.
// STRUCTURE
//   - config_pkg: debounce_state_e enum; default DebounceCycles/LongPressCycles constants.
//   - Sub-module sync_2ff_n: parameterised N-stage synchroniser with async active-high reset
//     and reset value; reused for future async inputs.
//   - Top holds: polarity inversion, FSM, deb_cnt, hold_cnt, long flag, output registers.
// TESTING (DebounceCycles=4, LongPressCycles=10, SyncStages=2 unless noted)
//   1. rst_i=1 with btn_i=1 -> all outputs 0. Release rst_i at cycle 0 with btn_i held
//      -> press_o pulse at cycle 6.
//   2. Clean press from 0->1 at cycle 0, held -> press_o 1 only at cycle 6; level_o 1 from cycle 6.
//   3. Bounce: btn_i 1 for 3 cycles, 0 for 2, repeated 5 times
//      -> press_o, level_o stay 0; then stable 1 -> press_o 6 cycles later.
//   4. Hold 30 cycles after press_o -> long_press_o single pulse 10 cycles after press_o,
//      never again that press.
//   5. Release after (4): 3-cycle 0-glitch ignored; stable 0 -> release_o 6 cycles later,
//      level_o 0. A re-press allows long_press_o again.
//   6. Assert rst_i while PRESSED -> level_o 0 same cycle (async), no release_o.
//      With ButtonActiveLow=1, btn_i=0 is treated as pressed; repeat test 2 with pin inverted.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// -----------------------------------------------------------------------------
// button_debounce_pkg
//   Shared definitions for the push-button conditioning block.
//   - debounce_state_e : debounce FSM state encoding (also exported on the
//                        debug port so checkers can follow the FSM directly).
//   - DEFAULT_*        : default timing constants for a 50 MHz-class clock.
//   - is_held()        : true in the two states where the button counts as
//                        pressed (debounced level high).
// -----------------------------------------------------------------------------
package button_debounce_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED        = 2'd0,
        ST_PRESS_PENDING   = 2'd1,
        ST_PRESSED         = 2'd2,
        ST_RELEASE_PENDING = 2'd3
    } debounce_state_e;

    // 1 ms of stability at 50 MHz before a level change is accepted.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 50_000;
    // 1 s of continuous hold at 50 MHz before a long press is reported.
    localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = 50_000_000;
    // Two flops are the minimum for a safe metastability window.
    localparam int unsigned DEFAULT_SYNC_STAGES       = 2;

    // The debounced level is high while the FSM is in PRESSED or while a
    // release is still being qualified.
    function automatic logic is_held(input debounce_state_e st);
        return (st == ST_PRESSED) || (st == ST_RELEASE_PENDING);
    endfunction

endpackage

// File: rtl/button_debounce_sync_2ff_n.sv
// -----------------------------------------------------------------------------
// button_debounce_sync_2ff_n
//   Generic N-stage flop synchroniser for a single asynchronous input.
//   Written without any button-specific logic so it can be reused for other
//   asynchronous pins.
//
// Parameters
//   Stages    number of flops in the chain (>= 2)
//   ResetVal  value loaded into every stage by reset
//
// Ports
//   clk_i   input  1  destination clock
//   rst_i   input  1  asynchronous reset, active-high
//   d_i     input  1  asynchronous data in
//   q_o     output 1  synchronised data out (last stage)
// -----------------------------------------------------------------------------
module button_debounce_sync_2ff_n #(
    parameter int unsigned Stages   = 2,
    parameter logic        ResetVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    if (Stages < 2) begin : g_bad_stages
        $error("button_debounce_sync_2ff_n: Stages must be >= 2");
    end

    logic [Stages-1:0] r_sync;

    // Shift towards the MSB; bit 0 is the only flop that can go metastable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= {Stages{ResetVal}};
        end else begin
            r_sync <= {r_sync[Stages-2:0], d_i};
        end
    end

    assign q_o = r_sync[Stages-1];

endmodule

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//   Turns one raw, bouncy, asynchronous push-button pin into clean events:
//   synchroniser -> debounce FSM -> registered one-cycle pulses + stable level.
//
// Parameters
//   DebounceCycles   consecutive stable cycles needed to accept a change (>= 1)
//   LongPressCycles  cycles held after an accepted press before long_press_o (>= 1)
//   SyncStages       flops in the input synchroniser (>= 2)
//   ButtonActiveLow  1: btn_i low means pressed (inverted before synchroniser)
//
// Ports
//   clk_i         input  1  system clock
//   rst_i         input  1  asynchronous reset, active-high
//   btn_i         input  1  raw button pin
//   level_o       output 1  debounced pressed level (1 = pressed)
//   press_o       output 1  one-cycle pulse on accepted press
//   release_o     output 1  one-cycle pulse on accepted release
//   long_press_o  output 1  one-cycle pulse, at most once per press
//   dbg_state_o   output 2  current debounce FSM state
//
// Every output comes straight from a flop; btn_i has no combinational path
// to any output.
// -----------------------------------------------------------------------------
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int unsigned DebounceCycles  = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LongPressCycles = DEFAULT_LONG_PRESS_CYCLES,
    parameter int unsigned SyncStages      = DEFAULT_SYNC_STAGES,
    parameter bit          ButtonActiveLow = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            btn_i,
    output logic            level_o,
    output logic            press_o,
    output logic            release_o,
    output logic            long_press_o,
    output debounce_state_e dbg_state_o
);

    if (DebounceCycles < 1) begin : g_bad_debounce
        $error("button_debounce: DebounceCycles must be >= 1");
    end
    if (LongPressCycles < 1) begin : g_bad_long
        $error("button_debounce: LongPressCycles must be >= 1");
    end
    if (SyncStages < 2) begin : g_bad_sync
        $error("button_debounce: SyncStages must be >= 2");
    end

    localparam int unsigned DebW  = $clog2(DebounceCycles + 1);
    localparam int unsigned HoldW = $clog2(LongPressCycles + 1);

    localparam logic [DebW-1:0]  DebLast  = DebW'(DebounceCycles - 1);
    localparam logic [DebW-1:0]  DebMax   = DebW'(DebounceCycles);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LongPressCycles - 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(LongPressCycles);

    // ------------------------------------------------------------------
    // Input conditioning: normalise polarity before synchronising so the
    // synchroniser reset value always means "not pressed".
    // ------------------------------------------------------------------
    logic w_btn_norm;
    logic w_s;

    assign w_btn_norm = ButtonActiveLow ? ~btn_i : btn_i;

    button_debounce_sync_2ff_n #(
        .Stages   (SyncStages),
        .ResetVal (1'b0)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (w_btn_norm),
        .q_o   (w_s)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    debounce_state_e   r_state;
    logic [DebW-1:0]   r_deb_cnt;
    logic [HoldW-1:0]  r_hold_cnt;
    logic              r_long_flag;
    logic              r_level;
    logic              r_press;
    logic              r_release;
    logic              r_long;

    debounce_state_e   w_state_next;
    logic [DebW-1:0]   w_deb_next;
    logic [HoldW-1:0]  w_hold_next;
    logic              w_flag_next;
    logic              w_level_next;
    logic              w_press_next;
    logic              w_release_next;
    logic              w_long_next;

    logic [DebW-1:0]   w_deb_inc;
    logic [HoldW-1:0]  w_hold_inc;
    logic              w_held;

    // Both counters stick at their ceiling instead of wrapping.
    assign w_deb_inc  = (r_deb_cnt  == DebMax)  ? r_deb_cnt  : r_deb_cnt  + DebW'(1);
    assign w_hold_inc = (r_hold_cnt == HoldMax) ? r_hold_cnt : r_hold_cnt + HoldW'(1);
    assign w_held     = is_held(r_state);

    // ------------------------------------------------------------------
    // Debounce FSM and event generation
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_deb_next     = r_deb_cnt;
        w_hold_next    = r_hold_cnt;
        w_flag_next    = r_long_flag;
        w_press_next   = 1'b0;
        w_release_next = 1'b0;
        w_long_next    = 1'b0;

        case (r_state)
            ST_RELEASED: begin
                if (w_s) begin
                    w_state_next = ST_PRESS_PENDING;
                    w_deb_next   = '0;
                end
            end

            ST_PRESS_PENDING: begin
                if (!w_s) begin
                    // Bounce: drop back without reporting anything.
                    w_state_next = ST_RELEASED;
                    w_deb_next   = '0;
                end else if (r_deb_cnt == DebLast) begin
                    w_state_next = ST_PRESSED;
                    w_press_next = 1'b1;
                    w_hold_next  = '0;
                end else begin
                    w_deb_next = w_deb_inc;
                end
            end

            ST_PRESSED: begin
                if (!w_s) begin
                    w_state_next = ST_RELEASE_PENDING;
                    w_deb_next   = '0;
                end
            end

            ST_RELEASE_PENDING: begin
                if (w_s) begin
                    // Release bounce: the hold time keeps accumulating, so a
                    // noisy contact cannot postpone the long-press report.
                    w_state_next = ST_PRESSED;
                end else if (r_deb_cnt == DebLast) begin
                    w_state_next   = ST_RELEASED;
                    w_release_next = 1'b1;
                    w_flag_next    = 1'b0;
                end else begin
                    w_deb_next = w_deb_inc;
                end
            end

            default: begin
                w_state_next = ST_RELEASED;
                w_deb_next   = '0;
            end
        endcase

        if (w_held) begin
            w_hold_next = w_hold_inc;
        end

        // Long press fires once per press. When the release is accepted in
        // the same cycle the hold threshold is reached, the release wins so
        // that at most one pulse output is ever high.
        if (w_held && (r_hold_cnt == HoldLast) && !r_long_flag && !w_release_next) begin
            w_long_next = 1'b1;
            w_flag_next = 1'b1;
        end

        w_level_next = is_held(w_state_next);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_RELEASED;
            r_deb_cnt   <= '0;
            r_hold_cnt  <= '0;
            r_long_flag <= 1'b0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_deb_cnt   <= w_deb_next;
            r_hold_cnt  <= w_hold_next;
            r_long_flag <= w_flag_next;
            r_level     <= w_level_next;
            r_press     <= w_press_next;
            r_release   <= w_release_next;
            r_long      <= w_long_next;
        end
    end

    assign level_o      = r_level;
    assign press_o      = r_press;
    assign release_o    = r_release;
    assign long_press_o = r_long;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_button_debounce.sv
`timescale 1ns/1ps
module tb_button_debounce;
    import button_debounce_pkg::*;

    localparam int DEB  = 4;
    localparam int LONG = 10;
    localparam int SYNC = 2;

    localparam logic [2:0] K_PRESS   = 3'b001;
    localparam logic [2:0] K_RELEASE = 3'b010;
    localparam logic [2:0] K_LONG    = 3'b100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b1;
    logic btn_pin_lo;

    always #5 clk = ~clk;

    assign btn_pin_lo = ~btn;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- DUTs ----------------
    logic hi_level, hi_press, hi_release, hi_long;
    logic lo_level, lo_press, lo_release, lo_long;
    debounce_state_e hi_state, lo_state;

    button_debounce #(
        .DebounceCycles (DEB),
        .LongPressCycles(LONG),
        .SyncStages     (SYNC),
        .ButtonActiveLow(1'b0)
    ) dut_hi (
        .clk_i       (clk),
        .rst_i       (rst),
        .btn_i       (btn),
        .level_o     (hi_level),
        .press_o     (hi_press),
        .release_o   (hi_release),
        .long_press_o(hi_long),
        .dbg_state_o (hi_state)
    );

    button_debounce #(
        .DebounceCycles (DEB),
        .LongPressCycles(LONG),
        .SyncStages     (SYNC),
        .ButtonActiveLow(1'b1)
    ) dut_lo (
        .clk_i       (clk),
        .rst_i       (rst),
        .btn_i       (btn_pin_lo),
        .level_o     (lo_level),
        .press_o     (lo_press),
        .release_o   (lo_release),
        .long_press_o(lo_long),
        .dbg_state_o (lo_state)
    );

    // ---------------- scoreboard ----------------
    // Entry: {kind[2:0], edge index[31:0]}
    logic [34:0] exp_q_hi[$];
    logic [34:0] exp_q_lo[$];
    bit          exp_level[int];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp, input int at_edge);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (edge %0d): got %0d, expected %0d", name, at_edge, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Level changes once the pressed/not-pressed sample seen after the
    // synchroniser has differed from the current level for DEB+1 edges in a
    // row, i.e. a pin stable from edge k is reported at edge k+SYNC+DEB.
    // Long press is due LONG edges after the press, if not released by then.
    bit samples[$];
    bit m_level;
    int m_run;
    bit m_long_armed;
    int m_long_due;

    task automatic model_reset();
        samples.delete();
        m_level      = 1'b0;
        m_run        = 0;
        m_long_armed = 1'b0;
        m_long_due   = 0;
    endtask

    // Called at a negedge: predicts what the coming posedge produces.
    task automatic model_edge(input bit b);
        int e;
        bit s;
        logic [2:0] kind;
        e    = edge_cnt;
        kind = 3'b000;
        samples.push_back(b);
        if (samples.size() > SYNC + 1) void'(samples.pop_front());
        s = (samples.size() == SYNC + 1) ? samples[0] : 1'b0;
        if (s != m_level) m_run++;
        else m_run = 0;
        if (m_run == DEB + 1) begin
            m_level = s;
            m_run   = 0;
            if (s) begin
                kind         = K_PRESS;
                m_long_armed = 1'b1;
                m_long_due   = e + LONG;
            end else begin
                kind         = K_RELEASE;
                m_long_armed = 1'b0;
            end
        end else if (m_long_armed && e == m_long_due) begin
            kind         = K_LONG;
            m_long_armed = 1'b0;
        end
        exp_level[e] = m_level;
        if (kind != 3'b000) begin
            exp_q_hi.push_back({kind, 32'(e)});
            exp_q_lo.push_back({kind, 32'(e)});
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin : mon_hi
        int last;
        logic [2:0] got, expk;
        logic [34:0] ent;
        bit lvl;
        last = edge_cnt - 1;
        got  = {hi_long, hi_release, hi_press};
        expk = 3'b000;
        while (exp_q_hi.size() > 0 && int'(exp_q_hi[0][31:0]) < last) begin
            ent = exp_q_hi.pop_front();
            check("hi pulse missed", 32'(0), 32'(ent[34:32]), int'(ent[31:0]));
        end
        if (exp_q_hi.size() > 0 && int'(exp_q_hi[0][31:0]) == last) begin
            ent  = exp_q_hi.pop_front();
            expk = ent[34:32];
        end
        check("hi pulses", 32'(got), 32'(expk), last);
        lvl = exp_level.exists(last) ? exp_level[last] : 1'b0;
        check("hi level", 32'(hi_level), 32'(lvl), last);
        if (rst) check("hi state in reset", 32'(hi_state), 32'(ST_RELEASED), last);
    end

    always @(negedge clk) begin : mon_lo
        int last;
        logic [2:0] got, expk;
        logic [34:0] ent;
        bit lvl;
        last = edge_cnt - 1;
        got  = {lo_long, lo_release, lo_press};
        expk = 3'b000;
        while (exp_q_lo.size() > 0 && int'(exp_q_lo[0][31:0]) < last) begin
            ent = exp_q_lo.pop_front();
            check("lo pulse missed", 32'(0), 32'(ent[34:32]), int'(ent[31:0]));
        end
        if (exp_q_lo.size() > 0 && int'(exp_q_lo[0][31:0]) == last) begin
            ent  = exp_q_lo.pop_front();
            expk = ent[34:32];
        end
        check("lo pulses", 32'(got), 32'(expk), last);
        lvl = exp_level.exists(last) ? exp_level[last] : 1'b0;
        check("lo level", 32'(lo_level), 32'(lvl), last);
        if (rst) check("lo state in reset", 32'(lo_state), 32'(ST_RELEASED), last);
    end

    // ---------------- driver tasks ----------------
    task automatic step(input bit b);
        @(negedge clk);
        btn = b;
        model_edge(b);
    endtask

    task automatic hold(input bit b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    // Deassert at the current negedge; the next posedge is the first
    // edge that samples the pin.
    task automatic release_reset(input bit b);
        rst = 1'b0;
        btn = b;
        model_reset();
        model_edge(b);
    endtask

    // Asynchronous assertion between edges; outputs must drop at once.
    task automatic async_reset(input int n);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async hi level", 32'(hi_level), 32'(0), edge_cnt);
        check("async lo level", 32'(lo_level), 32'(0), edge_cnt);
        check("async hi pulses", 32'({hi_long, hi_release, hi_press}), 32'(0), edge_cnt);
        check("async lo pulses", 32'({lo_long, lo_release, lo_press}), 32'(0), edge_cnt);
        model_reset();
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        rst = 1'b1;
        btn = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset hi outputs", 32'({hi_level, hi_long, hi_release, hi_press}), 32'(0), edge_cnt);
        check("reset lo outputs", 32'({lo_level, lo_long, lo_release, lo_press}), 32'(0), edge_cnt);
        @(negedge clk);

        // Held through reset release, then held long enough for a long press.
        release_reset(1'b1);
        hold(1'b1, 39);

        // Short release glitch ignored, then a real release.
        hold(1'b0, 3);
        hold(1'b1, 4);
        hold(1'b0, 12);

        // Clean press from idle, then release.
        hold(1'b1, 20);
        hold(1'b0, 12);

        // Bouncing contact never qualifies, then a stable press.
        for (int i = 0; i < 5; i++) begin
            hold(1'b1, 3);
            hold(1'b0, 2);
        end
        hold(1'b1, 14);
        hold(1'b0, 12);

        // Re-press to confirm long press is re-armed.
        hold(1'b1, 25);
        hold(1'b0, 12);

        // Reset while pressed: no release, then a fresh press.
        hold(1'b1, 12);
        async_reset(2);
        release_reset(1'b1);
        hold(1'b1, 20);
        hold(1'b0, 12);

        // Randomised segments.
        for (int i = 0; i < 150; i++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                async_reset($urandom_range(1, 3));
                release_reset(1'($urandom_range(0, 1)));
            end else if (r < 6) begin
                hold(1'($urandom_range(0, 1)), $urandom_range(10, 25));
            end else begin
                hold(1'($urandom_range(0, 1)), $urandom_range(1, 6));
            end
        end

        hold(1'b0, 20);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("hi queue drained", 32'(exp_q_hi.size()), 32'(0), edge_cnt);
        check("lo queue drained", 32'(exp_q_lo.size()), 32'(0), edge_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
